// File: rtl/core_types_pkg.sv
// ============================================================================
//  Module   : core_types_pkg
//  Purpose  : Shared memory-stage types, func3 encodings and access helpers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        Wreg;
  } MEM_out_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Illegal encodings are folded into the misaligned class so they never reach the bus.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return !f3_legal(f3) ||
           ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] f3_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f3_store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
//  Module   : mem_load_align
//  Purpose  : Selects the addressed lane of a read word and extends it by func3.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
  import core_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift = rdata >> {offset, 3'b000};
    case (func3)
      F3_B:    data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   data = {24'd0, w_shift[7:0]};
      F3_HU:   data = {16'd0, w_shift[15:0]};
      default: data = w_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : Memory-stage req/gnt/rvalid sequencer with stall and WB register.
//             Define DMEM_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import core_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_Wmem,
  input  logic        ex_Rmem,
  input  logic        ex_Wreg,
  input  logic [2:0]  ex_func3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_Wreg
);

  mem_state_t  r_state, w_next_state;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we, r_wreg;
  logic [4:0]  r_rd;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  MEM_out_t    r_wb;

  logic        w_mem_op, w_bad, w_issue, w_misalign, w_done, w_timeout;
  logic [31:0] w_load_data;

  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .offset (r_off),
    .func3  (r_func3),
    .data   (w_load_data)
  );

  assign w_mem_op   = ex_Wmem | ex_Rmem;
  assign w_bad      = f3_misaligned(ex_func3, ex_result[1:0]);
  assign w_issue    = ~Reset & (r_state == IDLE) & w_mem_op & ~w_bad;
  assign w_misalign = ~Reset & (r_state == IDLE) & w_mem_op & w_bad;
  assign w_done     = (r_state == WAIT) & dmem_rvalid;

`ifdef DMEM_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      r_cnt <= '0;
    else if (w_issue)
      r_cnt <= '0;
    else if ((r_state == REQ) || (r_state == WAIT))
      r_cnt <= r_cnt + 1'b1;
  end

  // A response arriving in the expiry cycle still completes normally.
  assign w_timeout = ((r_state == REQ) || (r_state == WAIT)) &&
                     (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) && !w_done;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next_state = dmem_gnt ? WAIT : REQ;
      REQ:     if (dmem_gnt) w_next_state = WAIT;
      WAIT:    if (dmem_rvalid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (w_timeout)
      w_next_state = IDLE;
  end

  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (w_issue) begin
      dmem_req   = 1'b1;
      dmem_we    = ex_Wmem;
      dmem_addr  = {ex_result[31:2], 2'b00};
      dmem_be    = f3_byte_en(ex_func3, ex_result[1:0]);
      dmem_wdata = f3_store_data(ex_func3, ex_rs2);
    end else if ((r_state == REQ) && !w_timeout) begin
      dmem_req   = 1'b1;
      dmem_we    = r_we;
      dmem_addr  = r_addr;
      dmem_be    = r_be;
      dmem_wdata = r_wdata;
    end
  end

  assign stall = w_issue | (((r_state == REQ) | ((r_state == WAIT) & ~dmem_rvalid)) & ~w_timeout);
  assign misalign_err = w_misalign;
  assign bus_err      = w_timeout;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_wreg  <= 1'b0;
      r_rd    <= '0;
      r_func3 <= '0;
      r_off   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_issue) begin
        r_addr  <= {ex_result[31:2], 2'b00};
        r_wdata <= f3_store_data(ex_func3, ex_rs2);
        r_be    <= f3_byte_en(ex_func3, ex_result[1:0]);
        r_we    <= ex_Wmem;
        r_wreg  <= ex_Wreg & ~ex_Wmem;
        r_rd    <= ex_rd;
        r_func3 <= ex_func3;
        r_off   <= ex_result[1:0];
      end
      if (w_misalign) begin
        r_wb.rd   <= ex_rd;
        r_wb.Wreg <= 1'b0;
      end else if ((r_state == IDLE) && !w_mem_op) begin
        r_wb <= '{rd: ex_rd, data: ex_result, Wreg: ex_Wreg};
      end else if (w_done) begin
        r_wb.rd   <= r_rd;
        r_wb.Wreg <= r_wreg;
        if (!r_we)
          r_wb.data <= w_load_data;
      end else if (w_timeout) begin
        r_wb.Wreg <= 1'b0;
      end
    end
  end

  assign wb_rd   = r_wb.rd;
  assign wb_data = r_wb.data;
  assign wb_Wreg = r_wb.Wreg;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
//  Module   : tb_mem_stage_ctrl
//  Purpose  : Self-checking bench for mem_stage_ctrl (vector table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int TO = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] ex_rs2, ex_result, dmem_rdata;
  logic [4:0]  ex_rd;
  logic        ex_Wmem, ex_Rmem, ex_Wreg;
  logic [2:0]  ex_func3;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        stall, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_Wreg;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_Wmem(ex_Wmem), .ex_Rmem(ex_Rmem), .ex_Wreg(ex_Wreg), .ex_func3(ex_func3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_Wreg(wb_Wreg)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wreg;
    logic        chk_rd;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wm;
    logic        rm;
    logic        wr;
    logic [2:0]  f3;
    logic        mis;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic wreg,
                      input logic chk_rd, input logic chk_data);
    exp_t e;
    e.rd = rd; e.data = data; e.wreg = wreg; e.chk_rd = chk_rd; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, " wb_Wreg"}, wb_Wreg, e.wreg);
    if (e.chk_rd)   chk({nm, " wb_rd"}, wb_rd, e.rd);
    if (e.chk_data) chk({nm, " wb_data"}, wb_data, e.data);
  endtask

  task automatic ex_clear();
    ex_rd = '0; ex_result = '0; ex_rs2 = '0;
    ex_Wmem = 1'b0; ex_Rmem = 1'b0; ex_Wreg = 1'b0; ex_func3 = '0;
  endtask

  task automatic single(input string nm, input vec_t v);
    @(negedge Clock);
    ex_rd = v.rd; ex_result = v.res; ex_rs2 = 32'h5555_AAAA;
    ex_Wmem = v.wm; ex_Rmem = v.rm; ex_Wreg = v.wr; ex_func3 = v.f3;
    push(v.rd, v.res, v.mis ? 1'b0 : v.wr, 1'b1, !v.mis);
    #1;
    chk({nm, " misalign_err"}, misalign_err, v.mis);
    chk({nm, " dmem_req"}, dmem_req, 1'b0);
    chk({nm, " stall"}, stall, 1'b0);
    @(posedge Clock); #1;
    sb_pop(nm);
  endtask

  task automatic mem_op(input string nm, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic st, input logic rm, input logic wreg,
                        input logic [2:0] f3, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    @(negedge Clock);
    ex_rd = rd; ex_result = addr; ex_rs2 = rs2;
    ex_Wmem = st; ex_Rmem = rm; ex_Wreg = wreg; ex_func3 = f3;
    dmem_gnt = (gnt_dly == 0);
    push(rd, exp_wb, st ? 1'b0 : wreg, !st, !st);
    for (int k = 0; k <= gnt_dly; k++) begin
      if (k > 0) begin
        @(negedge Clock);
        ex_result = ~addr; ex_rs2 = ~rs2; ex_func3 = f3 ^ 3'b001;
        dmem_gnt = (k == gnt_dly);
      end
      #1;
      chk({nm, " dmem_req"}, dmem_req, 1'b1);
      chk({nm, " dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({nm, " dmem_be"}, dmem_be, exp_be);
      chk({nm, " dmem_we"}, dmem_we, st);
      if (st) chk({nm, " dmem_wdata"}, dmem_wdata, exp_wdata);
      chk({nm, " stall"}, stall, 1'b1);
      chk({nm, " bus_err"}, bus_err, 1'b0);
    end
    for (int k = 0; k < rv_dly; k++) begin
      @(negedge Clock);
      dmem_gnt = 1'b1;
      #1;
      chk({nm, " wait dmem_req"}, dmem_req, 1'b0);
      chk({nm, " wait stall"}, stall, 1'b1);
      chk({nm, " wait bus_err"}, bus_err, 1'b0);
    end
    @(negedge Clock);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    chk({nm, " rvalid stall"}, stall, 1'b0);
    chk({nm, " rvalid dmem_req"}, dmem_req, 1'b0);
    @(posedge Clock); #1;
    dmem_rvalid = 1'b0;
    ex_clear();
    sb_pop(nm);
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[off*8 +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] off, input logic [2:0] f3);
    logic [3:0] be;
    for (int j = 0; j < 4; j++) begin
      if (f3[1:0] == 2'b00)      be[j] = (j == int'(off));
      else if (f3[1:0] == 2'b01) be[j] = ((j / 2) == (int'(off) / 2));
      else                       be[j] = 1'b1;
    end
    return be;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdat;

    tbl[0]  = '{5'd5,  32'h0000_0042, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0};
    tbl[1]  = '{5'd9,  32'h0000_0006, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1};
    tbl[2]  = '{5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0};
    tbl[3]  = '{5'd10, 32'h0000_0101, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1};
    tbl[4]  = '{5'd6,  32'h0000_0013, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[5]  = '{5'd11, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1};
    tbl[6]  = '{5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[7]  = '{5'd12, 32'h0000_0003, 1'b0, 1'b1, 1'b1, 3'b101, 1'b1};
    tbl[8]  = '{5'd7,  32'h1234_5678, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[9]  = '{5'd13, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1};
    tbl[10] = '{5'd14, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1};
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

    Reset = 1'b1;
    ex_clear();
    ex_Rmem = 1'b1; ex_Wreg = 1'b1; ex_func3 = 3'b010; ex_result = 32'h100;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge Clock); #1;
    chk("reset dmem_req", dmem_req, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset wb_Wreg", wb_Wreg, 1'b0);
    chk("reset wb_data", wb_data, 32'h0);
    chk("reset wb_rd", wb_rd, 5'd0);
    chk("reset misalign_err", misalign_err, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    ex_clear();

    for (int i = 0; i < 11; i++)
      single($sformatf("vec%0d", i), tbl[i]);

    single("alu_b2b", tbl[0]);
    mem_op("LHU", 5'd8, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b1, 3'b101, 0, 0,
           32'h0000_9ABC, 4'b0011, 32'h0, 32'h0000_9ABC);
    mem_op("LB", 5'd3, 32'h0000_1003, 32'h0, 1'b0, 1'b1, 1'b1, 3'b000, 0, 0,
           32'h80FF_FFFF, 4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op("SH", 5'd4, 32'h0000_2002, 32'h1234_ABCD, 1'b1, 1'b0, 1'b1, 3'b001, 3, 0,
           32'hDEAD_BEEF, 4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_op("SB_both", 5'd9, 32'h0000_0041, 32'h0000_00A5, 1'b1, 1'b1, 1'b1, 3'b000, 1, 1,
           32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_op("SW", 5'd2, 32'h0000_0044, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 3'b010, 0, 2,
           32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    mem_op("LW_wait", 5'd1, 32'h0000_0080, 32'h0, 1'b0, 1'b1, 1'b1, 3'b010, 1, 12,
           32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF);

    for (int i = 0; i < 12; i++) begin
      f3   = f3s[$urandom_range(0, 4)];
      off  = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      rdat = $urandom;
      mem_op($sformatf("rand%0d", i), 5'(i + 16), 32'h3000 + 32'(i * 16) + 32'(off),
             32'h0, 1'b0, 1'b1, 1'b1, f3, $urandom_range(0, 2), $urandom_range(0, 1),
             rdat, be_model(off, f3), 32'h0, ld_model(rdat, off, f3));
    end

    // Reset in the middle of an outstanding load, response arriving afterwards
    @(negedge Clock);
    ex_rd = 5'd3; ex_result = 32'h100; ex_Rmem = 1'b1; ex_Wreg = 1'b1; ex_func3 = 3'b010;
    dmem_gnt = 1'b1;
    @(negedge Clock);
    dmem_gnt = 1'b0;
    ex_clear();
    #1;
    chk("rst_wait stall before", stall, 1'b1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("rst_wait dmem_req", dmem_req, 1'b0);
    chk("rst_wait stall", stall, 1'b0);
    chk("rst_wait wb_Wreg", wb_Wreg, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    ex_rd = 5'd7; ex_result = 32'h77; ex_Wreg = 1'b1;
    push(5'd7, 32'h77, 1'b1, 1'b1, 1'b1);
    #1;
    chk("late_rvalid stall", stall, 1'b0);
    chk("late_rvalid dmem_req", dmem_req, 1'b0);
    @(posedge Clock); #1;
    dmem_rvalid = 1'b0;
    ex_clear();
    sb_pop("late_rvalid");

`ifdef DMEM_TIMEOUT_EN
    single("alu_pre_to", tbl[0]);
    @(negedge Clock);
    ex_rd = 5'd21; ex_result = 32'h20; ex_Rmem = 1'b1; ex_Wreg = 1'b1; ex_func3 = 3'b010;
    dmem_gnt = 1'b1;
    #1;
    chk("to issue stall", stall, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge Clock);
      dmem_gnt = 1'b0;
      ex_clear();
      #1;
      if (k < TO) begin
        chk($sformatf("to c%0d bus_err", k), bus_err, 1'b0);
        chk($sformatf("to c%0d stall", k), stall, 1'b1);
      end else begin
        chk("to bus_err", bus_err, 1'b1);
        chk("to stall", stall, 1'b0);
        chk("to dmem_req", dmem_req, 1'b0);
        chk("to misalign_err", misalign_err, 1'b0);
      end
    end
    @(posedge Clock); #1;
    chk("to wb_Wreg", wb_Wreg, 1'b0);
    @(negedge Clock); #1;
    chk("to bus_err pulse end", bus_err, 1'b0);
    chk("to stall after", stall, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
